// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side bundle for the UART receiver: byte, valid/read handshake,
// framing-error pulse and overrun flag. master = receiver, slave = consumer.
interface uart_rx_ctrl_if;
  logic [7:0] out;
  logic       vld;
  logic       rd;
  logic       err;
  logic       ovr;

  modport master (
    output out,
    output vld,
    output err,
    output ovr,
    input  rd
  );

  modport slave (
    input  out,
    input  vld,
    input  err,
    input  ovr,
    output rd
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 3-stage rx sync, start detect, mid-bit sampling
// of 8 data bits (LSB first), stop check, valid/read handshake, framing error.
// Ports: clk, rst (sync, active-high), rx (async line, idle high),
//   bus (master modport): out[7:0], vld, err (1-clk pulse), ovr, rd in.
// Option: define UART_RX_OVERRUN_EN to drop new bytes on overrun and keep a
//   sticky ovr flag; otherwise new bytes overwrite out and ovr is tied 0.
module uart_rx_ctrl #(
  parameter int BIT_TIME = 1250
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_rx_ctrl_if.master bus
);

  localparam int TW = $clog2(BIT_TIME);
  localparam logic [TW-1:0] T_HALF = TW'(BIT_TIME / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(BIT_TIME - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    sync_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    out_q, out_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic          ovr_q, ovr_d;

  logic line;
  logic fall;
  logic accept;
  logic t_zero;
  logic done;

  assign line   = sync_q[2];
  assign fall   = sync_q[2] & ~sync_q[1];
  assign accept = bus.rd & vld_q;
  assign t_zero = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    err_d   = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          timer_d = T_HALF;
        end
      end
      START: begin
        if (!t_zero) begin
          timer_d = timer_q - 1'b1;
        end else if (line) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          cnt_d   = '0;
          timer_d = T_FULL;
        end
      end
      DATA: begin
        if (!t_zero) begin
          timer_d = timer_q - 1'b1;
        end else begin
          shift_d = {line, shift_q[7:1]};
          cnt_d   = cnt_q + 1'b1;
          timer_d = T_FULL;
          if (cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (!t_zero) begin
          timer_d = timer_q - 1'b1;
        end else if (line) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = BRK;
        end
      end
      BRK: begin
        if (line) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake: an accepted rd clears vld; a completed byte in the same clk
  // re-arms it, so done takes priority over the clear.
  always_comb begin
    out_d = out_q;
    vld_d = vld_q;
    ovr_d = ovr_q;
    if (accept) begin
      vld_d = 1'b0;
      ovr_d = 1'b0;
    end
`ifdef UART_RX_OVERRUN_EN
    if (done) begin
      if (vld_q && !bus.rd) begin
        ovr_d = 1'b1;
      end else begin
        out_d = shift_q;
        vld_d = 1'b1;
      end
    end
`else
    ovr_d = 1'b0;
    if (done) begin
      out_d = shift_q;
      vld_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 3'b111;
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rx};
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.out = out_q;
  assign bus.vld = vld_q;
  assign bus.err = err_q;
`ifdef UART_RX_OVERRUN_EN
  assign bus.ovr = ovr_q;
`else
  assign bus.ovr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at BIT_TIME=8: idle, single byte, false
// start, framing error with held-low line, overrun, reset mid-frame.
module tb_uart_rx_ctrl;

  localparam int BT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   errs  = 0;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.BIT_TIME(BT)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.err === 1'b1) errs++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(BT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BT);
    end
    rx = stop;
    tick(BT);
  endtask

  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    while (bus.vld !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    chk(tag, {7'd0, bus.vld}, 8'd1);
  endtask

  task automatic read1();
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
  endtask

  initial begin
    int e0;
    bus.rd = 1'b0;

    // 1: reset, idle
    tick(2);
    chk("rst_vld", {7'd0, bus.vld}, 8'd0);
    chk("rst_out", bus.out, 8'h00);
    rst = 1'b0;
    tick(20);
    chk("idle_vld", {7'd0, bus.vld}, 8'd0);
    chk("idle_err", {7'd0, bus.err}, 8'd0);
    chk("idle_out", bus.out, 8'h00);
    chk("idle_ovr", {7'd0, bus.ovr}, 8'd0);

    // 2: single byte, then read
    rx = 1'b1;
    send(8'h55, 1'b1);
    wait_vld("b55_vld");
    chk("b55_out", bus.out, 8'h55);
    tick(10);
    chk("b55_hold", bus.out, 8'h55);
    chk("b55_stay", {7'd0, bus.vld}, 8'd1);
    read1();
    chk("b55_rd", {7'd0, bus.vld}, 8'd0);
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
    chk("rd_idle", {7'd0, bus.vld}, 8'd0);

    // 3: false start
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(20);
    chk("fs_vld", {7'd0, bus.vld}, 8'd0);
    chk("fs_err", errs[7:0], 8'd0);

    // 4: framing error, line held low
    send(8'hA5, 1'b0);
    tick(30);
    chk("fe_err", errs[7:0], 8'd1);
    chk("fe_vld", {7'd0, bus.vld}, 8'd0);
    rx = 1'b1;
    tick(20);
    chk("brk_err", errs[7:0], 8'd1);
    chk("brk_vld", {7'd0, bus.vld}, 8'd0);

    // 5: overrun
    rx = 1'b1;
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    tick(8);
    chk("ov_vld", {7'd0, bus.vld}, 8'd1);
`ifdef UART_RX_OVERRUN_EN
    chk("ov_out", bus.out, 8'hA5);
    chk("ov_ovr", {7'd0, bus.ovr}, 8'd1);
`else
    chk("ov_out", bus.out, 8'h3C);
    chk("ov_ovr", {7'd0, bus.ovr}, 8'd0);
`endif
    read1();
    chk("ov_rd_vld", {7'd0, bus.vld}, 8'd0);
    chk("ov_rd_ovr", {7'd0, bus.ovr}, 8'd0);

    // 6: reset mid-frame, then a clean byte
    e0 = errs;
    rx = 1'b0;
    tick(BT);
    rx = 1'b1;
    tick(4 * BT);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);
    chk("mr_vld", {7'd0, bus.vld}, 8'd0);
    chk("mr_out", bus.out, 8'h00);
    send(8'h12, 1'b1);
    wait_vld("b12_vld");
    chk("b12_out", bus.out, 8'h12);
    tick(20);
    chk("b12_err", 8'(errs - e0), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
